// File: rtl/avalon_uart_responder_if.sv
// rtl/avalon_uart_responder_if.sv - Avalon-MM register access bundle for the UART responder
interface avalon_uart_responder_if;
  logic [4:0]  avs_address;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_waitrequest;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, avs_waitrequest
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, avs_waitrequest
  );
endinterface

// File: rtl/avalon_uart_responder.sv
// rtl/avalon_uart_responder.sv - Avalon-MM UART register front-end with RX/TX byte FIFOs
// Optional sticky error flags in STATUS[9:8]: define UART_RESPONDER_ERR_FLAGS_EN.
module avalon_uart_responder #(
  parameter int FIFO_DEPTH  = 4,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                   avm_clk,
  input  logic                   avm_rst,
  avalon_uart_responder_if.slave bus,
  input  logic [7:0]             i_rx_data,
  input  logic                   i_rx_valid,
  output logic                   o_rx_ready,
  output logic [7:0]             o_tx_data,
  output logic                   o_tx_valid,
  input  logic                   i_tx_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);
  localparam logic [2:0]    WAIT_LAST = 3'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [4:0]    ADDR_RX     = 5'd0;
  localparam logic [4:0]    ADDR_TX     = 5'd4;
  localparam logic [4:0]    ADDR_STATUS = 5'd8;

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t      state;
  logic [2:0]  wait_cnt;
  logic [4:0]  acc_addr;
  logic        acc_write;
  logic [7:0]  acc_wdata;
  logic        waitrequest_q;

  // Only the low byte of writedata carries a TX character.
  logic unused_wdata;
  assign unused_wdata = ^bus.avs_writedata[31:8];

  // Access sequencer: latch the request, hold waitrequest for WAIT_CYCLES, then one ACK cycle.
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      acc_addr      <= '0;
      acc_write     <= 1'b0;
      acc_wdata     <= '0;
      waitrequest_q <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.avs_read || bus.avs_write) begin
            acc_addr  <= bus.avs_address;
            // A simultaneous read+write is serviced as a read.
            acc_write <= bus.avs_write && !bus.avs_read;
            acc_wdata <= bus.avs_writedata[7:0];
            wait_cnt  <= '0;
            if (WAIT_CYCLES > 0) begin
              state <= BUSY;
            end else begin
              state         <= ACK;
              waitrequest_q <= 1'b0;
            end
          end
        end
        BUSY: begin
          if (wait_cnt == WAIT_LAST) begin
            state         <= ACK;
            waitrequest_q <= 1'b0;
            wait_cnt      <= '0;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        ACK: begin
          state         <= IDLE;
          waitrequest_q <= 1'b1;
        end
        default: begin
          state         <= IDLE;
          waitrequest_q <= 1'b1;
        end
      endcase
    end
  end

  logic ack;
  logic rd_rx;
  logic rd_status;
  logic wr_tx;
  assign ack       = (state == ACK);
  assign rd_rx     = ack && !acc_write && (acc_addr == ADDR_RX);
  assign rd_status = ack && !acc_write && (acc_addr == ADDR_STATUS);
  assign wr_tx     = ack &&  acc_write && (acc_addr == ADDR_TX);

  // ---------------- RX FIFO ----------------
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [PW-1:0] rx_wr;
  logic [PW-1:0] rx_rd;
  logic [CW-1:0] rx_count;
  logic          rx_push;
  logic          rx_pop;

  assign o_rx_ready = (rx_count != FULL);
  assign rx_push    = i_rx_valid && o_rx_ready;
  assign rx_pop     = rd_rx && (rx_count != '0);

  // RX storage: written on every accepted stream byte.
  always_ff @(posedge avm_clk) begin
    if (rx_push) rx_mem[rx_wr] <= i_rx_data;
  end

  // RX pointers and occupancy; push and pop may coincide.
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      rx_wr    <= '0;
      rx_rd    <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)  rx_rd <= rx_rd + 1'b1;
      rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
    end
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wr;
  logic [PW-1:0] tx_rd;
  logic [CW-1:0] tx_count;
  logic          tx_push;
  logic          tx_pop;
  logic [PW-1:0] tx_rd_next;
  logic [CW-1:0] tx_count_next;
  logic [7:0]    tx_head_next;
  logic [7:0]    tx_head;

  // A full FIFO drops the byte even if a pop happens in the same cycle.
  assign tx_push       = wr_tx && (tx_count != FULL);
  assign tx_pop        = o_tx_valid && i_tx_ready;
  assign tx_rd_next    = tx_pop ? tx_rd + 1'b1 : tx_rd;
  assign tx_count_next = tx_count + CW'(tx_push) - CW'(tx_pop);
  assign o_tx_valid    = (tx_count != '0);
  assign o_tx_data     = tx_head;

  // Next head: the byte being pushed bypasses storage when it becomes the sole entry.
  always_comb begin
    tx_head_next = '0;
    if (tx_count_next != '0) begin
      if (tx_push && (tx_wr == tx_rd_next)) tx_head_next = acc_wdata;
      else                                  tx_head_next = tx_mem[tx_rd_next];
    end
  end

  // TX storage: written when a register write is committed.
  always_ff @(posedge avm_clk) begin
    if (tx_push) tx_mem[tx_wr] <= acc_wdata;
  end

  // TX pointers, occupancy and registered head byte.
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      tx_wr    <= '0;
      tx_rd    <= '0;
      tx_count <= '0;
      tx_head  <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + 1'b1;
      tx_rd    <= tx_rd_next;
      tx_count <= tx_count_next;
      tx_head  <= tx_head_next;
    end
  end

  // ---------------- STATUS / error flags ----------------
  logic [31:0] status;

`ifdef UART_RESPONDER_ERR_FLAGS_EN
  logic tx_ovf;
  logic rx_unf;
  logic clr_flags;
  assign clr_flags = ack && acc_write && (acc_addr == ADDR_STATUS);

  // Sticky error flags; a same-cycle event beats the clear.
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      tx_ovf <= 1'b0;
      rx_unf <= 1'b0;
    end else begin
      if (wr_tx && (tx_count == FULL)) tx_ovf <= 1'b1;
      else if (clr_flags)              tx_ovf <= 1'b0;
      if (rd_rx && (rx_count == '0))   rx_unf <= 1'b1;
      else if (clr_flags)              rx_unf <= 1'b0;
    end
  end

  // STATUS word, including the sticky flags.
  always_comb begin
    status    = '0;
    status[7] = (rx_count != '0);
    status[6] = (tx_count != FULL);
    status[8] = tx_ovf;
    status[9] = rx_unf;
  end
`else
  // STATUS word: FIFO levels only.
  always_comb begin
    status    = '0;
    status[7] = (rx_count != '0);
    status[6] = (tx_count != FULL);
  end
`endif

  // Read data is decoded from live FIFO state during the ACK cycle only.
  always_comb begin
    bus.avs_readdata = '0;
    if (rd_rx && (rx_count != '0)) bus.avs_readdata = {24'b0, rx_mem[rx_rd]};
    else if (rd_status)            bus.avs_readdata = status;
  end

  assign bus.avs_waitrequest = waitrequest_q;

endmodule
